// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM encoding for the IFU/LSU arbiter.
// Single-beat, single-outstanding AXI4 master.
package axi_pkg;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_AR   = 5'b00010,
        ST_R    = 5'b00100,
        ST_AW_W = 5'b01000,
        ST_B    = 5'b10000
    } state_e;

    localparam logic [3:0] AXI_ID_IFU   = 4'd0;
    localparam logic [3:0] AXI_ID_LSU   = 4'd1;

    localparam logic [2:0] AXSIZE_1     = 3'd0;
    localparam logic [2:0] AXSIZE_2     = 3'd1;
    localparam logic [2:0] AXSIZE_4     = 3'd2;
    localparam logic [2:0] AXSIZE_8     = 3'd3;
    localparam logic [1:0] AXBURST_INCR = 2'b01;
    localparam logic [7:0] AXLEN_SINGLE = 8'd0;
    localparam logic [2:0] AXPROT_INSTR = 3'b100;
    localparam logic [2:0] AXPROT_DATA  = 3'b000;
    localparam logic [1:0] XRESP_OKAY   = 2'b00;

    // A response is bad if the slave flagged an error or answered the wrong ID.
    function automatic logic resp_bad(input logic [1:0] resp, input logic [3:0] id,
                                      input logic [3:0] exp_id);
        return (resp != XRESP_OKAY) || (id != exp_id);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; bit 0 = IFU, bit 1 = LSU.
// r_last_lsu resets to 1 so the IFU wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_last_lsu
);

    logic       r_last_lsu;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last_lsu ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_lsu <= 1'b1;
        end else if (|w_gnt) begin
            r_last_lsu <= w_gnt[1];
        end
    end

    assign o_gnt      = w_gnt;
    assign o_last_lsu = r_last_lsu;

endmodule

// File: rtl/axi_arbiter.sv
// Shares one AXI4 master between the IFU (read-only) and the LSU (read/write).
// One transaction in flight, LEN = 0; all VALID/READY outputs come from registers.
module axi_arbiter #(
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 64,
    parameter logic [3:0] ID_IFU = 4'd0,
    parameter logic [3:0] ID_LSU = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [31:0]       ifu_rdata,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [2:0]        lsu_size,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_bvalid,
    output logic              resp_err,
    output logic [4:0]        o_dbg_state,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARLOCK,
    output logic [3:0]        ARCACHE,
    output logic [2:0]        ARPROT,
    output logic [3:0]        ARQOS,
    output logic [3:0]        ARREGION,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [3:0]        AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [7:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWLOCK,
    output logic [3:0]        AWCACHE,
    output logic [2:0]        AWPROT,
    output logic [3:0]        AWQOS,
    output logic [3:0]        AWREGION,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [7:0]        WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [3:0]        BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    import axi_pkg::*;

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [2:0]        r_prot;
    logic [3:0]        r_id;
    logic              r_owner_lsu;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wstrb;
    logic              r_aw_done;
    logic              r_w_done;

    logic [1:0]        w_gnt;
    logic              w_last_lsu;
    logic              w_awvalid;
    logic              w_wvalid;
    logic              w_aw_fin;
    logic              w_w_fin;
    logic              w_r_last;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_state == ST_IDLE),
        .i_req      ({lsu_req, ifu_req}),
        .o_gnt      (w_gnt),
        .o_last_lsu (w_last_lsu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt[0])      w_next = ST_AR;
                else if (w_gnt[1]) w_next = lsu_we ? ST_AW_W : ST_AR;
            end
            ST_AR:   if (ARREADY) w_next = ST_R;
            ST_R:    if (w_r_last) w_next = ST_IDLE;
            ST_AW_W: if (w_aw_fin && w_w_fin) w_next = ST_B;
            ST_B:    if (BVALID) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_awvalid  = (r_state == ST_AW_W) && !r_aw_done;
        w_wvalid   = (r_state == ST_AW_W) && !r_w_done;
        w_aw_fin   = r_aw_done || (w_awvalid && AWREADY);
        w_w_fin    = r_w_done  || (w_wvalid && WREADY);
        w_r_last   = (r_state == ST_R) && RVALID && RLAST;
        ifu_gnt    = w_gnt[0];
        lsu_gnt    = w_gnt[1];
        ifu_rvalid = w_r_last && !r_owner_lsu;
        lsu_rvalid = w_r_last && r_owner_lsu;
        lsu_bvalid = (r_state == ST_B) && BVALID;
        resp_err   = 1'b0;
        if (w_r_last)
            resp_err = resp_bad(RRESP, RID, r_id);
        else if (lsu_bvalid)
            resp_err = resp_bad(BRESP, BID, ID_LSU);
    end

    // Request fields are captured at grant so requesters may move on immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_size      <= '0;
            r_prot      <= '0;
            r_id        <= '0;
            r_owner_lsu <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else if (w_gnt[0]) begin
            r_addr      <= ifu_addr;
            r_size      <= AXSIZE_4;
            r_prot      <= AXPROT_INSTR;
            r_id        <= ID_IFU;
            r_owner_lsu <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else if (w_gnt[1]) begin
            r_addr      <= lsu_addr;
            r_size      <= lsu_size;
            r_prot      <= AXPROT_DATA;
            r_id        <= ID_LSU;
            r_owner_lsu <= 1'b1;
            r_wdata     <= lsu_wdata;
            r_wstrb     <= lsu_wstrb;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else if (r_state == ST_AW_W) begin
            r_aw_done   <= w_aw_fin;
            r_w_done    <= w_w_fin;
        end
    end

    assign o_dbg_state = r_state;
    assign ifu_rdata   = RDATA[31:0];
    assign lsu_rdata   = RDATA;

    assign ARID     = r_id;
    assign ARADDR   = r_addr;
    assign ARLEN    = AXLEN_SINGLE;
    assign ARSIZE   = r_size;
    assign ARBURST  = AXBURST_INCR;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'd0;
    assign ARPROT   = r_prot;
    assign ARQOS    = 4'd0;
    assign ARREGION = 4'd0;
    assign ARVALID  = (r_state == ST_AR);
    assign RREADY   = (r_state == ST_R);

    assign AWID     = r_id;
    assign AWADDR   = r_addr;
    assign AWLEN    = AXLEN_SINGLE;
    assign AWSIZE   = r_size;
    assign AWBURST  = AXBURST_INCR;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'd0;
    assign AWPROT   = r_prot;
    assign AWQOS    = 4'd0;
    assign AWREGION = 4'd0;
    assign AWVALID  = w_awvalid;
    assign WDATA    = r_wdata;
    assign WSTRB    = r_wstrb;
    assign WLAST    = 1'b1;
    assign WVALID   = w_wvalid;
    assign BREADY   = (r_state == ST_B);

    logic w_unused;
    assign w_unused = w_last_lsu;

endmodule
